// File: rtl/smi_axi_pkg.sv
// Shared constants and types for the SMI-to-AXI write adaptor: response codes,
// splitter states and the write-response framing bytes.
package smi_axi_pkg;

    localparam logic [7:0] WRITE_RESP_ID_BYTE = 8'hFE;
    localparam logic [7:0] WRITE_RESP_EOFC    = 8'd4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ZERO
    } splitter_state_t;

    // The AXI encoding already orders severity numerically, so worst is max.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/smi_axi_id_tracker.sv
// AXI ID pool and per-ID bookkeeping: outstanding burst count, merged status,
// SMI tag and issue-complete flag; flags the B that finishes a command.
module smi_axi_id_tracker
    import smi_axi_pkg::*;
#(
    parameter int AxiIdWidth = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  alloc,
    input  logic [15:0]           alloc_tag,
    input  logic                  aw_fire,
    input  logic                  issue_last,
    input  logic [AxiIdWidth-1:0] aw_id,
    input  logic                  b_fire,
    input  logic [AxiIdWidth-1:0] b_id,
    input  logic [1:0]            b_resp,
    output logic                  free_any,
    output logic [AxiIdWidth-1:0] free_id,
    output logic                  done,
    output logic [15:0]           done_tag,
    output logic [1:0]            done_status
);

    localparam int NumIds = 1 << AxiIdWidth;

    logic [NumIds-1:0] free_pool;
    logic [NumIds-1:0] issue_done;
    logic [15:0]       count  [NumIds];
    logic [15:0]       tag    [NumIds];
    logic [1:0]        status [NumIds];
    logic              same_id;

    // An AW and a B on the same ID in one cycle cancel out in the count.
    assign same_id = aw_fire && b_fire && (aw_id == b_id);

    always_comb begin
        free_id = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (free_pool[i]) free_id = AxiIdWidth'(i);
        end
    end

    assign free_any    = |free_pool;
    assign done_tag    = tag[b_id];
    assign done_status = worst_resp(status[b_id], b_resp);
    assign done        = b_fire && !same_id && (count[b_id] == 16'd1) &&
                         (issue_done[b_id] || (issue_last && (aw_id == b_id)));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            free_pool  <= '1;
            issue_done <= '0;
            for (int i = 0; i < NumIds; i++) begin
                count[i]  <= '0;
                tag[i]    <= '0;
                status[i] <= RESP_OKAY;
            end
        end else begin
            if (alloc) begin
                free_pool[free_id]  <= 1'b0;
                tag[free_id]        <= alloc_tag;
                status[free_id]     <= RESP_OKAY;
                issue_done[free_id] <= 1'b0;
            end
            if (aw_fire && !same_id) count[aw_id] <= count[aw_id] + 16'd1;
            if (b_fire && !same_id)  count[b_id]  <= count[b_id] - 16'd1;
            if (b_fire)              status[b_id] <= done_status;
            if (issue_last)          issue_done[aw_id] <= 1'b1;
            if (done) begin
                issue_done[b_id] <= 1'b0;
                free_pool[b_id]  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/smi_axi_write_burst_splitter.sv
// Splits SMI write commands into boundary-safe AXI AW bursts with a matching
// W beat-count stream, and folds each command's B responses into one SMI response.
module smi_axi_write_burst_splitter
    import smi_axi_pkg::*;
#(
    parameter int DataIndexSize     = 4,
    parameter int AxiIdWidth        = 4,
    parameter int MaxBurstLen       = 16,
    parameter int BoundaryIndexSize = 12,
    localparam int DataWidth        = 8 << DataIndexSize
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  cmdReady,
    input  logic [63:0]           cmdAddr,
    input  logic [15:0]           cmdLen,
    input  logic [15:0]           cmdTag,
    input  logic                  cmdCacheable,
    output logic                  cmdStop,
    output logic                  axiAWValid,
    input  logic                  axiAWReady,
    output logic [AxiIdWidth-1:0] axiAWId,
    output logic [63:0]           axiAWAddr,
    output logic [7:0]            axiAWLen,
    output logic [2:0]            axiAWSize,
    output logic [3:0]            axiAWCache,
    output logic                  wBurstReady,
    output logic [7:0]            wBurstLen,
    input  logic                  wBurstStop,
    input  logic                  axiBValid,
    output logic                  axiBReady,
    input  logic [AxiIdWidth-1:0] axiBId,
    input  logic [1:0]            axiBResp,
    output logic                  smiRespReady,
    output logic [7:0]            smiRespEofc,
    output logic [DataWidth-1:0]  smiRespData,
    input  logic                  smiRespStop
);

    localparam logic [63:0] BeatBytes = 64'd1 << DataIndexSize;
    localparam logic [63:0] BndSpan   = 64'd1 << (BoundaryIndexSize - DataIndexSize);
    localparam logic [63:0] MaxBeats  = 64'(MaxBurstLen);

    splitter_state_t state;
    logic            run;
    logic [15:0]     cur_rem;
    logic [15:0]     zero_tag;
    logic            resp_valid;
    logic [31:0]     resp_word;

    logic cmd_fire, aw_fire, w_fire, b_fire, issue_step, last_burst, alloc;
    logic free_any, done;
    logic [AxiIdWidth-1:0] free_id;
    logic [15:0] done_tag;
    logic [1:0]  done_status;
    logic [63:0] consumed, next_addr, calc_addr, calc_bnd, calc_rem_beats, calc_beats;
    logic [15:0] next_rem, calc_rem;
    logic [7:0]  burst_len;

    // run keeps the command and B channels closed until the first edge after reset.
    assign cmdStop      = !(run && (state == IDLE) && free_any);
    assign axiBReady    = run && !resp_valid;
    assign cmd_fire     = cmdReady && !cmdStop;
    assign aw_fire      = axiAWValid && axiAWReady;
    assign w_fire       = wBurstReady && !wBurstStop;
    assign b_fire       = axiBValid && axiBReady;
    assign alloc        = cmd_fire && (cmdLen != 16'd0);
    assign issue_step   = (state == ISSUE) && (!axiAWValid || aw_fire) && (!wBurstReady || w_fire);
    assign axiAWSize    = 3'(DataIndexSize);
    assign smiRespReady = resp_valid;
    assign smiRespEofc  = WRITE_RESP_EOFC;
    assign smiRespData  = DataWidth'(resp_word);

    // Only the first sub-burst can start mid-beat; its unaligned head is not consumed data.
    always_comb begin
        consumed   = ((64'(axiAWLen) + 64'd1) << DataIndexSize) - (axiAWAddr & (BeatBytes - 64'd1));
        last_burst = consumed >= 64'(cur_rem);
        next_addr  = axiAWAddr + consumed;
        next_rem   = last_burst ? 16'd0 : cur_rem - 16'(consumed);
        calc_addr  = (state == IDLE) ? cmdAddr : next_addr;
        calc_rem   = (state == IDLE) ? cmdLen : next_rem;
        calc_bnd   = BndSpan - ((calc_addr >> DataIndexSize) & (BndSpan - 64'd1));
        calc_rem_beats = (64'(calc_rem) + (calc_addr & (BeatBytes - 64'd1)) + BeatBytes - 64'd1)
                         >> DataIndexSize;
        calc_beats = MaxBeats;
        if (calc_bnd < calc_beats)       calc_beats = calc_bnd;
        if (calc_rem_beats < calc_beats) calc_beats = calc_rem_beats;
        burst_len  = 8'(calc_beats - 64'd1);
    end

    smi_axi_id_tracker #(
        .AxiIdWidth (AxiIdWidth)
    ) u_tracker (
        .clk         (clk),
        .nreset      (nreset),
        .alloc       (alloc),
        .alloc_tag   (cmdTag),
        .aw_fire     (aw_fire),
        .issue_last  (issue_step && last_burst),
        .aw_id       (axiAWId),
        .b_fire      (b_fire),
        .b_id        (axiBId),
        .b_resp      (axiBResp),
        .free_any    (free_any),
        .free_id     (free_id),
        .done        (done),
        .done_tag    (done_tag),
        .done_status (done_status)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            run         <= 1'b0;
            axiAWValid  <= 1'b0;
            axiAWId     <= '0;
            axiAWAddr   <= '0;
            axiAWLen    <= '0;
            axiAWCache  <= '0;
            wBurstReady <= 1'b0;
            wBurstLen   <= '0;
            cur_rem     <= '0;
            zero_tag    <= '0;
            resp_valid  <= 1'b0;
            resp_word   <= '0;
        end else begin
            run <= 1'b1;
            if (aw_fire) axiAWValid <= 1'b0;
            if (w_fire)  wBurstReady <= 1'b0;
            if (resp_valid && !smiRespStop) resp_valid <= 1'b0;
            if (done) begin
                resp_valid <= 1'b1;
                resp_word  <= {done_tag, 6'd0, done_status, WRITE_RESP_ID_BYTE};
            end
            case (state)
                IDLE: begin
                    if (cmd_fire && (cmdLen == 16'd0)) begin
                        zero_tag <= cmdTag;
                        state    <= ZERO;
                    end else if (cmd_fire) begin
                        axiAWValid  <= 1'b1;
                        wBurstReady <= 1'b1;
                        axiAWId     <= free_id;
                        axiAWAddr   <= calc_addr;
                        axiAWLen    <= burst_len;
                        axiAWCache  <= {3'b001, cmdCacheable};
                        wBurstLen   <= burst_len;
                        cur_rem     <= calc_rem;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_step && last_burst) begin
                        state <= IDLE;
                    end else if (issue_step) begin
                        axiAWValid  <= 1'b1;
                        wBurstReady <= 1'b1;
                        axiAWAddr   <= calc_addr;
                        axiAWLen    <= burst_len;
                        wBurstLen   <= burst_len;
                        cur_rem     <= calc_rem;
                    end
                end
                ZERO: begin
                    if (!resp_valid && !done) begin
                        resp_valid <= 1'b1;
                        resp_word  <= {zero_tag, 6'd0, RESP_OKAY, WRITE_RESP_ID_BYTE};
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/smi_axi_write_burst_splitter.md
Name: smi_axi_write_burst_splitter

Overview:
- Address/response half of the next-generation SMI-to-AXI write adaptor.
- Takes parsed SMI write commands (address, byte length, tag, cacheable) and splits each into AXI AW bursts that never cross a 2^BoundaryIndexSize byte boundary and never exceed MaxBurstLen beats.
- Issues a matching beat-count stream to the existing byte-align/W datapath.
- Merges every B response of a command into exactly one SMI write response carrying the worst status, with out-of-order completion across IDs.

Parameters:
- DataIndexSize, 4, log2 bytes per AXI beat; DataWidth = 8 << DataIndexSize.
- AxiIdWidth, 4, AXI ID width; 2^AxiIdWidth commands may be in flight.
- MaxBurstLen, 16, maximum beats per AW burst, 1..256.
- BoundaryIndexSize, 12, log2 of the no-cross boundary (4 KB); must be ≥ DataIndexSize.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cmdReady  in  1  command valid
- cmdAddr  in  64  start byte address
- cmdLen  in  16  byte count
- cmdTag  in  16  SMI tag
- cmdCacheable  in  1  selects AWCACHE bit 0
- cmdStop  out  1  command backpressure
- axiAWValid/axiAWReady  out/in  1  AW handshake
- axiAWId  out  AxiIdWidth  AW ID
- axiAWAddr  out  64  AW address
- axiAWLen  out  8  AW length
- axiAWSize  out  3  constant DataIndexSize
- axiAWCache  out  4  {3'b001, cacheable}
- wBurstReady  out  1  beat-count valid
- wBurstLen  out  8  beats-1 for the next W burst
- wBurstStop  in  1  beat-count backpressure
- axiBValid  in  1  B valid
- axiBReady  out  1  B ready
- axiBId  in  AxiIdWidth  B ID
- axiBResp  in  2  B response
- smiRespReady  out  1  SMI response valid
- smiRespEofc  out  8  SMI response EOFC
- smiRespData  out  DataWidth  SMI response data
- smiRespStop  in  1  SMI response backpressure

Behaviour:
- Reset (async, nreset low):
  - axiAWValid, wBurstReady, axiBReady and smiRespReady are 0; cmdStop is 1.
  - Every ID is free; all per-ID counters are 0; state is IDLE.
  - Reset mid-operation discards all tracking; no responses are emitted for lost commands.
- Handshakes:
  - SMI side: a transfer occurs when Ready=1 and Stop=0.
  - AXI side: a transfer occurs when Valid=1 and Ready=1.
  - Valid/Ready (SMI) and payload are held stable until accepted.
- ID pool: a bit vector; the lowest-numbered free ID is selected.
- Per-ID state: tag, cacheable, 16-bit outstanding count, worst status, and an issueDone flag.
- IDLE:
  - cmdStop = 0 only when an ID is free.
  - On acceptance with cmdLen != 0: allocate the ID, latch addr/remaining bytes/tag, clear status, go to ISSUE.
  - cmdLen == 0: go to ZERO; no ID is used.
- ISSUE: per sub-burst, with A = current address and R = remaining bytes:
  - beatsToBnd = 2^(B-D) - ((A>>D) mod 2^(B-D))
  - remBeats = ((A mod 2^D) + R + 2^D - 1) >> D
  - beats = min(MaxBurstLen, beatsToBnd, remBeats)
  - AWLen = wBurstLen = beats-1. AW address = A (unaligned only on the first sub-burst).
  - consumed = beats*2^D - (A mod 2^D); A += consumed; R -= consumed.
- AW and beat-count outputs:
  - Both assert together and are registered: valid the cycle after the command is accepted or the previous sub-burst completes.
  - They handshake independently; each holds its own pending flag.
  - The next sub-burst is computed only after both have been accepted.
  - The outstanding count increments on AW acceptance.
  - When the accepted sub-burst makes R == 0, set issueDone and return to IDLE.
- ZERO: wait for the response register to be free and no B completion that cycle; emit a response with status OKAY and cmdTag; go to IDLE.
- B channel:
  - axiBReady = 1 unless the response register is occupied.
  - On a B transfer: decrement count[BId]; status[BId] = max(status, BResp), where DECERR > SLVERR > EXOKAY > OKAY.
  - Simultaneous AW acceptance and B for the same ID leaves the count unchanged.
- Completion:
  - Occurs when a B drives the count to 0 and issueDone=1. A B can never arrive before the final AW.
  - Load the response register, clear issueDone, and free the ID in the same edge.
  - A freed ID is available to IDLE on the next cycle.
- Response format:
  - smiRespEofc = 4.
  - smiRespData = {zeros, tag[15:0], 6'd0, status[1:0], 8'hFE}.
- Latency:
  - Command accept to first AW valid: 1 cycle.
  - Final B to smiRespReady: 1 cycle.

Decomposition:
- Shared package smi_axi_pkg:
  - WRITE_RESP_ID_BYTE = 8'hFE
  - AXI resp codes OKAY/EXOKAY/SLVERR/DECERR
  - Splitter state encoding IDLE/ISSUE/ZERO
  - Write response EOFC constant 4
- Sub-module smi_axi_id_tracker: free pool, priority encoder, per-ID count/status/tag/issueDone, completion strobe.
- The splitter FSM and burst arithmetic stay in the top module.

Test Plan:
- Command addr 0x1000, len 64, tag 0x00AB; B OKAY -> one AW (ID 0, addr 0x1000, len 3, cache 0011); wBurstLen 3; smiRespData low 32 bits = 0x00AB00FE.
- Command addr 0x0FF8, len 32 -> AW addr 0x0FF8 len 0, then AW addr 0x1000 len 1; beat counts 0,1; one response after both B.
- Command addr 0x0, len 1024; B resps OKAY, SLVERR, OKAY, OKAY -> AWs at 0x000/0x100/0x200/0x300, each len 15, all same ID; single response with status 2.
- 17 commands with B withheld -> IDs 0..15 issued and cmdStop held 1; return B for ID 5 -> 17th command issued with ID 5 one cycle after the freeing edge.
- Zero-length command with tag 0x1234 -> no AW or beat count; response 0x123400FE with status OKAY.
- nreset low during the second sub-burst with smiRespStop = 1 -> all valids 0 asynchronously; after release, a new command gets ID 0.
